// File: rtl/ysyx_22040127_key_finder_pkg.sv
// Shared definitions for the reverse key lookup block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   kf_state_e  - lookup controller states (IDLE / SCAN / RESP)
//   KF_MISS_KEY - key reported on a miss when no default key is configured
//
// Table entries are kept as separate valid/key/data arrays inside the table
// module, because a struct whose field widths follow module parameters cannot
// be declared portably in a package.
package ysyx_22040127_keyfind_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } kf_state_e;

    localparam int KF_MISS_KEY = 0;

endpackage

// File: rtl/ysyx_22040127_key_finder_if.sv
// Bundle of table-write, lookup-request and lookup-response signals.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready and resp_valid/resp_ready handshakes.
//
// Modports:
//   master - drives writes/clears/requests, consumes responses
//   slave  - the key finder itself
// Build option YSYX_22040127_KEYFIND_DEFAULT_EN adds def_key (the key
// reported on a miss).
interface ysyx_22040127_key_finder_if #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 64,
    parameter int IDX_LEN  = $clog2(NR_KEY)
);
    // table maintenance
    logic                wr_en;
    logic [IDX_LEN-1:0]  wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                clr_all;

    // lookup request
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_data;

    // lookup response
    logic                resp_valid;
    logic                resp_ready;
    logic                resp_hit;
    logic [KEY_LEN-1:0]  resp_key;
    logic [IDX_LEN-1:0]  resp_idx;

`ifdef YSYX_22040127_KEYFIND_DEFAULT_EN
    logic [KEY_LEN-1:0]  def_key;

    modport master (
        output wr_en, wr_idx, wr_key, wr_data, clr_all,
        output req_valid, req_data, resp_ready, def_key,
        input  req_ready, resp_valid, resp_hit, resp_key, resp_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, clr_all,
        input  req_valid, req_data, resp_ready, def_key,
        output req_ready, resp_valid, resp_hit, resp_key, resp_idx
    );
`else
    modport master (
        output wr_en, wr_idx, wr_key, wr_data, clr_all,
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_key, resp_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_key, wr_data, clr_all,
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_key, resp_idx
    );
`endif

endinterface

// File: rtl/ysyx_22040127_key_table.sv
// Key/data storage with one write port, a global clear and one registered read port.
// Latency: writes land on the next edge; read data appears one edge after rd_idx.
// Backpressure: none; accepts a write and a read every cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears valid bits)
//   wr_en/wr_idx/...    write key+data into entry wr_idx and mark it valid
//   clr_all             invalidate every entry (wins over wr_en)
//   rd_idx              entry to read
//   rd_valid/key/data   registered contents of entry rd_idx as they stood
//                       before the capturing edge
module ysyx_22040127_key_table #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 64,
    parameter int IDX_LEN  = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr_all,
    input  logic [IDX_LEN-1:0]  rd_idx,
    output logic                rd_valid,
    output logic [KEY_LEN-1:0]  rd_key,
    output logic [DATA_LEN-1:0] rd_data
);

    logic [NR_KEY-1:0]   vld_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    // Valid bits are the only state that must be defined after reset.
    // A clear arriving on the same edge as a read also kills that read, so
    // once clr_all has been seen no later compare can hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (clr_all) begin
                vld_q <= '0;
            end else if (wr_en) begin
                vld_q[wr_idx] <= 1'b1;
            end
            rd_valid <= vld_q[rd_idx] && !clr_all;
        end
    end

    // Key/data fields are don't-care while invalid, so they carry no reset.
    // The read samples pre-edge contents: a write to the entry being read in
    // the same cycle is only visible to later reads.
    always_ff @(posedge clk) begin
        if (wr_en && !clr_all) begin
            key_q[wr_idx]  <= wr_key;
            data_q[wr_idx] <= wr_data;
        end
        rd_key  <= key_q[rd_idx];
        rd_data <= data_q[rd_idx];
    end

endmodule

// File: rtl/ysyx_22040127_key_finder.sv
// Reverse lookup: finds the lowest-index valid table entry whose data equals req_data.
// Latency: hit at entry i -> resp_valid 2+i cycles after accept; miss -> NR_KEY+1 cycles.
// Backpressure: one lookup in flight; req_ready low until the response is taken.
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset (aborts any lookup)
//   kf        slave side of ysyx_22040127_key_finder_if (writes, request, response)
// Build option YSYX_22040127_KEYFIND_DEFAULT_EN: a miss reports kf.def_key,
// passed through combinationally while the response is presented; otherwise a
// miss reports key 0. A miss always reports index NR_KEY-1.
module ysyx_22040127_key_finder
    import ysyx_22040127_keyfind_pkg::*;
#(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 64,
    parameter int IDX_LEN  = $clog2(NR_KEY)
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22040127_key_finder_if.slave kf
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SCAN = ST_SCAN;
    localparam logic [1:0] RESP = ST_RESP;

    localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NR_KEY - 1);

    logic [1:0]          state_q;
    logic [IDX_LEN-1:0]  scan_idx_q;   // entry being read from the table
    logic [IDX_LEN-1:0]  cmp_idx_q;    // entry whose read data is compared now
    logic                cmp_live_q;   // table read data belongs to this lookup
    logic [DATA_LEN-1:0] req_data_q;
    logic                resp_hit_q;
    logic [KEY_LEN-1:0]  resp_key_q;
    logic [IDX_LEN-1:0]  resp_idx_q;

    logic                tbl_valid;
    logic [KEY_LEN-1:0]  tbl_key;
    logic [DATA_LEN-1:0] tbl_data;
    logic                cmp_hit;
    logic                cmp_last;

    ysyx_22040127_key_table #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .IDX_LEN  (IDX_LEN)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (kf.wr_en),
        .wr_idx   (kf.wr_idx),
        .wr_key   (kf.wr_key),
        .wr_data  (kf.wr_data),
        .clr_all  (kf.clr_all),
        .rd_idx   (scan_idx_q),
        .rd_valid (tbl_valid),
        .rd_key   (tbl_key),
        .rd_data  (tbl_data)
    );

    // The read port is registered, so the scan is a two-stage pipeline:
    // scan_idx_q issues reads, cmp_idx_q tracks the entry being compared.
    // Scanning stops at the first hit, which gives lowest-index priority.
    assign cmp_hit  = cmp_live_q && tbl_valid && (tbl_data == req_data_q);
    assign cmp_last = cmp_live_q && (cmp_idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            cmp_idx_q  <= '0;
            cmp_live_q <= 1'b0;
            req_data_q <= '0;
            resp_hit_q <= 1'b0;
            resp_key_q <= '0;
            resp_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (kf.req_valid) begin
                        req_data_q <= kf.req_data;
                        scan_idx_q <= '0;
                        cmp_live_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end

                SCAN: begin
                    cmp_idx_q  <= scan_idx_q;
                    cmp_live_q <= 1'b1;
                    // Saturate rather than wrap; the compare stage ends the scan.
                    if (scan_idx_q != LAST_IDX) begin
                        scan_idx_q <= scan_idx_q + IDX_LEN'(1);
                    end

                    if (cmp_hit) begin
                        resp_hit_q <= 1'b1;
                        resp_key_q <= tbl_key;
                        resp_idx_q <= cmp_idx_q;
                        cmp_live_q <= 1'b0;
                        state_q    <= RESP;
                    end else if (cmp_last) begin
                        resp_hit_q <= 1'b0;
                        resp_key_q <= KEY_LEN'(KF_MISS_KEY);
                        resp_idx_q <= LAST_IDX;
                        cmp_live_q <= 1'b0;
                        state_q    <= RESP;
                    end
                end

                RESP: begin
                    if (kf.resp_ready) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign kf.req_ready  = (state_q == IDLE);
    assign kf.resp_valid = (state_q == RESP);
    assign kf.resp_hit   = resp_hit_q;
    assign kf.resp_idx   = resp_idx_q;

`ifdef YSYX_22040127_KEYFIND_DEFAULT_EN
    // def_key is not latched: the consumer sees whatever it drives at the
    // handshake cycle.
    assign kf.resp_key = (state_q == RESP && !resp_hit_q) ? kf.def_key : resp_key_q;
`else
    assign kf.resp_key = resp_key_q;
`endif

endmodule

// File: tb/tb_ysyx_22040127_key_finder.sv
// Bench for ysyx_22040127_key_finder: directed lookups with literal
// expectations, plus a cycle-accurate reference model compared every cycle.
module tb_ysyx_22040127_key_finder;
    import ysyx_22040127_keyfind_pkg::*;

    localparam int NR = 8;
`ifdef YSYX_22040127_KEYFIND_DEFAULT_EN
    localparam logic [3:0] MK = 4'h7;
`else
    localparam logic [3:0] MK = 4'h0;
`endif

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ysyx_22040127_key_finder_if #(.NR_KEY(NR), .KEY_LEN(4), .DATA_LEN(64)) kf ();

    ysyx_22040127_key_finder #(.NR_KEY(NR), .KEY_LEN(4), .DATA_LEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .kf  (kf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Entry k of a lookup accepted at edge T is judged by its contents just
    // before edge T+1+k (a clear on that edge hides it). A hit on entry k is
    // presented from edge T+2+k, a miss from edge T+1+NR.
    logic        m_valid [NR];
    logic [3:0]  m_key   [NR];
    logic [63:0] m_data  [NR];
    logic [63:0] m_req;
    bit          m_busy, m_resp, m_found, m_hit;
    int          m_t, m_fidx;
    logic [3:0]  m_fkey, m_rkey;
    logic [2:0]  m_ridx;

    initial begin
        m_busy = 0; m_resp = 0; m_found = 0; m_hit = 0;
        m_t = 0; m_fidx = 0; m_fkey = 0; m_rkey = 0; m_ridx = 0; m_req = 0;
        for (int i = 0; i < NR; i++) begin
            m_valid[i] = 1'b0; m_key[i] = 0; m_data[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
                m_busy = 0;
                m_resp = 0;
            end else begin
                if (m_resp) begin
                    if (kf.resp_ready) m_resp = 0;
                end else if (m_busy) begin
                    m_t++;
                    if (!m_found && m_t >= 1 && m_t <= NR) begin
                        if (m_valid[m_t-1] && !kf.clr_all && m_data[m_t-1] == m_req) begin
                            m_found = 1;
                            m_fidx  = m_t - 1;
                            m_fkey  = m_key[m_t-1];
                        end
                    end
                    if ((m_found && m_t == m_fidx + 2) || (!m_found && m_t == NR + 1)) begin
                        m_resp = 1;
                        m_busy = 0;
                        m_hit  = m_found;
                        m_rkey = m_fkey;
                        m_ridx = m_found ? 3'(m_fidx) : 3'(NR - 1);
                    end
                end else if (kf.req_valid) begin
                    m_busy  = 1;
                    m_req   = kf.req_data;
                    m_t     = 0;
                    m_found = 0;
                end
                if (kf.clr_all) begin
                    for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
                end else if (kf.wr_en) begin
                    m_valid[kf.wr_idx] = 1'b1;
                    m_key[kf.wr_idx]   = kf.wr_key;
                    m_data[kf.wr_idx]  = kf.wr_data;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cyc_req_ready", 64'(kf.req_ready), 64'(!m_busy && !m_resp));
                chk("cyc_resp_valid", 64'(kf.resp_valid), 64'(m_resp));
                if (m_resp) begin
                    chk("cyc_resp_hit", 64'(kf.resp_hit), 64'(m_hit));
                    chk("cyc_resp_key", 64'(kf.resp_key), 64'(m_hit ? m_rkey : MK));
                    chk("cyc_resp_idx", 64'(kf.resp_idx), 64'(m_ridx));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [2:0] i, input logic [3:0] k, input logic [63:0] d);
        kf.wr_en = 1'b1; kf.wr_idx = i; kf.wr_key = k; kf.wr_data = d;
        @(posedge clk); #1;
        kf.wr_en = 1'b0;
    endtask

    // act_kind: 0 none, 1 write (a_idx/a_key/a_data), 2 clr_all; driven in the
    // cycle following edge T+act_cyc so it lands on edge T+act_cyc+1.
    task automatic lookup(input string nm, input logic [63:0] d,
                          input int act_cyc, input int act_kind,
                          input logic [2:0] a_idx, input logic [3:0] a_key, input logic [63:0] a_data,
                          input int e_lat, input logic e_hit, input logic [3:0] e_key, input logic [2:0] e_idx);
        int lat;
        kf.req_valid = 1'b1;
        kf.req_data  = d;
        @(posedge clk); #1;
        kf.req_valid = 1'b0;
        lat = 0;
        while (!kf.resp_valid && lat < 40) begin
            if (lat == act_cyc && act_kind == 1) begin
                kf.wr_en = 1'b1; kf.wr_idx = a_idx; kf.wr_key = a_key; kf.wr_data = a_data;
            end
            if (lat == act_cyc && act_kind == 2) kf.clr_all = 1'b1;
            @(posedge clk); #1;
            kf.wr_en   = 1'b0;
            kf.clr_all = 1'b0;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(e_lat));
        chk({nm, "_hit"}, 64'(kf.resp_hit), 64'(e_hit));
        chk({nm, "_key"}, 64'(kf.resp_key), 64'(e_key));
        chk({nm, "_idx"}, 64'(kf.resp_idx), 64'(e_idx));
        @(posedge clk); #1;   // handshake with resp_ready=1
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        rst = 1'b1;
        kf.wr_en = 0; kf.wr_idx = 0; kf.wr_key = 0; kf.wr_data = 0; kf.clr_all = 0;
        kf.req_valid = 0; kf.req_data = 0; kf.resp_ready = 1'b1;
`ifdef YSYX_22040127_KEYFIND_DEFAULT_EN
        kf.def_key = 4'h7;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(kf.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(kf.resp_valid), 64'd0);
        chk("rst_resp_hit", 64'(kf.resp_hit), 64'd0);
        chk("rst_resp_key", 64'(kf.resp_key), 64'd0);
        chk("rst_resp_idx", 64'(kf.resp_idx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        lookup("miss_empty", 64'h55, -1, 0, 0, 0, 0, 9, 1'b0, MK, 3'd7);

        wr(3'd3, 4'hA, 64'h1234);
        lookup("basic_hit", 64'h1234, -1, 0, 0, 0, 0, 5, 1'b1, 4'hA, 3'd3);

        wr(3'd1, 4'h1, 64'hF0);
        wr(3'd5, 4'h5, 64'hF0);
        lookup("dup_data", 64'hF0, -1, 0, 0, 0, 0, 3, 1'b1, 4'h1, 3'd1);

        // Backpressure: hold resp_ready low, offer a competing request.
        kf.resp_ready = 1'b0;
        kf.req_valid  = 1'b1;
        kf.req_data   = 64'hF0;
        @(posedge clk); #1;
        kf.req_valid = 1'b0;
        lat = 0;
        while (!kf.resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'd3);
        kf.req_valid = 1'b1;
        kf.req_data  = 64'h1234;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(kf.resp_valid), 64'd1);
            chk("bp_hold_key", 64'(kf.resp_key), 64'h1);
            chk("bp_hold_idx", 64'(kf.resp_idx), 64'd1);
            chk("bp_req_ready", 64'(kf.req_ready), 64'd0);
        end
        kf.resp_ready = 1'b1;
        @(posedge clk); #1;
        kf.req_valid = 1'b0;
        chk("bp_after_valid", 64'(kf.resp_valid), 64'd0);
        chk("bp_after_ready", 64'(kf.req_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_ignored_req", 64'(kf.req_ready), 64'd1);

        wr(3'd6, 4'h6, 64'h66);
        lookup("hit_idx6", 64'h66, -1, 0, 0, 0, 0, 8, 1'b1, 4'h6, 3'd6);

        // Entry 0 written after the scan has already read it.
        lookup("wr_passed", 64'hBEEF, 1, 1, 3'd0, 4'hC, 64'hBEEF, 9, 1'b0, MK, 3'd7);
        lookup("wr_passed_seen", 64'hBEEF, -1, 0, 0, 0, 0, 2, 1'b1, 4'hC, 3'd0);

        // Entry 2 written on the very edge it is read: old contents compared.
        lookup("wr_same", 64'hCAFE, 2, 1, 3'd2, 4'h2, 64'hCAFE, 9, 1'b0, MK, 3'd7);
        lookup("wr_same_seen", 64'hCAFE, -1, 0, 0, 0, 0, 4, 1'b1, 4'h2, 3'd2);

        // Clear early in a scan whose match would be entry 6.
        lookup("clr_mid", 64'h66, 2, 2, 0, 0, 0, 9, 1'b0, MK, 3'd7);

        // Reset in the middle of a scan.
        wr(3'd4, 4'h4, 64'h44);
        kf.req_valid = 1'b1;
        kf.req_data  = 64'h44;
        @(posedge clk); #1;
        kf.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_resp_valid", 64'(kf.resp_valid), 64'd0);
        chk("rstmid_req_ready", 64'(kf.req_ready), 64'd1);
        chk("rstmid_resp_hit", 64'(kf.resp_hit), 64'd0);
        chk("rstmid_resp_idx", 64'(kf.resp_idx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        lookup("post_rst_miss", 64'h44, -1, 0, 0, 0, 0, 9, 1'b0, MK, 3'd7);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_key_finder.md
# ysyx_22040127_key_finder

- Writable key/data table with a sequential reverse lookup: given a data value, returns the key (and entry index) that maps to it.
- Forward key-to-data selection in the datapath is combinational over a fixed table; this block runs the opposite direction and owns its table contents.
- Used by decode/debug logic that must recover an opcode or CSR key from a known value.
- Scans one entry per cycle behind valid/ready handshakes on request and response.

## Interface
Parameters:
- NR_KEY, 8, number of table entries (≥2)
- KEY_LEN, 4, key width
- DATA_LEN, 64, data width
- IDX_LEN, $clog2(NR_KEY), entry index width (derived)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  write entry wr_idx, set its valid bit
- wr_idx  in  IDX_LEN  entry to write
- wr_key  in  KEY_LEN  key to store
- wr_data  in  DATA_LEN  data to store
- clr_all  in  1  invalidate every entry
- req_valid  in  1  lookup request valid
- req_ready  out  1  block accepts a request
- req_data  in  DATA_LEN  data value to search for
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts the result
- resp_hit  out  1  a matching valid entry was found
- resp_key  out  KEY_LEN  key of the matching entry
- resp_idx  out  IDX_LEN  index of the matching entry
- def_key  in  KEY_LEN  miss key; present only with the macro below

## Operation
- **Storage:** NR_KEY entries of {valid, key, data}.
  - Reset clears all valid bits; key and data fields are don't-care.
  - clr_all beats wr_en in the same cycle.
  - Writes take effect on the next edge.
- **FSM states:** IDLE, SCAN, RESP.
  - **IDLE:** req_ready=1. On req_valid&&req_ready, register req_data, set idx=0, go to SCAN.
  - **SCAN:** compare the registered entry[idx] (valid && data==req_data).
    - Hit: latch key and idx, set hit=1, go to RESP.
    - Miss with idx==NR_KEY-1: hit=0, go to RESP.
    - Otherwise idx+1.
  - **RESP:** resp_valid=1 and outputs held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE.
- **Priority:** lowest matching index wins; duplicate data values are legal.
- **Miss outputs:** resp_idx=NR_KEY-1; resp_key per Configuration.
- **Writes during SCAN:** allowed.
  - A write to an index already passed is invisible to this lookup.
  - A write to the index being compared this cycle is seen only by later lookups; the compare uses pre-edge contents.
  - clr_all mid-scan makes all remaining compares miss.
- **Counter:** idx never wraps; the scan terminates at NR_KEY-1.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_hit=0, resp_key=0, resp_idx=0, state IDLE. Reset mid-scan or mid-response aborts immediately.
- Request accepted at edge T:
  - match at entry i gives resp_valid high from T+2+i;
  - miss gives resp_valid high from T+1+NR_KEY.
- req_ready is low in SCAN and RESP; there is no request overlap.
- A request can be accepted in the cycle after the response handshake, since IDLE is entered at that edge.
- resp_ready may be asserted early; it is only sampled in RESP.

## Configuration
- Macro: YSYX_22040127_KEYFIND_DEFAULT_EN.
- **Defined:** def_key port exists; on a miss, resp_key = def_key sampled at the response handshake cycle (combinational pass-through while in RESP).
- **Undefined:** no def_key port; on a miss, resp_key=0.
- resp_hit behaves identically in both builds.

## Structure
- Package ysyx_22040127_keyfind_pkg:
  - state enum (IDLE=2'd0, SCAN=2'd1, RESP=2'd2);
  - parameterised entry struct is not portable, so use separate valid/key/data arrays;
  - the miss-key constant 0.
- Sub-module ysyx_22040127_key_table: the storage array.
  - Write port, clr_all, and one read port indexed by idx.
  - The FSM stays in the top.

## Test plan
- **Basic hit:** reset, write idx3={key 4'hA, data 64'h1234}, request 64'h1234 with resp_ready=1 → resp_valid 5 cycles after accept (T+2+3), resp_hit=1, resp_key=4'hA, resp_idx=3.
- **Miss:** empty table, request 64'h55 → resp_valid at T+1+8, resp_hit=0, resp_key=0, or def_key=4'h7 with macro defined.
- **Duplicate data:** idx1 and idx5 both data 64'hF0, keys 4'h1/4'h5 → resp_key=4'h1, resp_idx=1.
- **Backpressure:** hold resp_ready=0 for 4 cycles → outputs stable, req_ready=0; a new req_valid is ignored until the handshake completes.
- **Write/clear during scan:**
  - write idx0 data=X after the scan has passed it → miss;
  - clr_all at T+2 with the match at idx6 → miss.
- **Reset mid-SCAN** → next cycle resp_valid=0, req_ready=1, all entries invalid.
